// File: rtl/seq_logic_unit_pkg.sv
// rtl/seq_logic_unit_pkg.sv - op encodings and FSM state type for seq_logic_unit
package seq_logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XNOR = 3'b100;
    localparam logic [2:0] OP_ANDN = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_logic_unit_logic_chunk.sv
// rtl/seq_logic_unit_logic_chunk.sv - combinational bitwise op and popcount on one chunk
module logic_chunk
    import seq_logic_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]             a,
    input  logic [CHUNK-1:0]             b,
    input  logic [2:0]                   op,
    output logic [CHUNK-1:0]             res,
    output logic [$clog2(CHUNK+1)-1:0]   pop
);

    localparam int PW = $clog2(CHUNK + 1);

    always_comb begin
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_ANDN: res = a & ~b;
            // illegal codes yield zero so the whole result and count stay zero
            default: res = '0;
        endcase
        pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + PW'(res[i]);
        end
    end

endmodule

// File: rtl/seq_logic_unit.sv
// rtl/seq_logic_unit.sv - chunk-serial bitwise logic unit with result popcount
module seq_logic_unit
    import seq_logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_low,
    output logic [WIDTH-1:0] res_high
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int PW     = $clog2(CHUNK + 1);

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  a_q, b_q, acc_low, low_next;
    logic [2:0]        op_q;
    logic [CNT_W-1:0]  acc_cnt, cnt_next;
    logic [31:0]       shamt;
    logic [CHUNK-1:0]  a_sl, b_sl, chunk_res;
    logic [PW-1:0]     chunk_pop;
    logic              launch, last;

    assign launch = start && (state == IDLE || state == DONE);
    assign last   = (idx == IDX_W'(NCHUNK - 1));
    assign shamt  = 32'(idx) * 32'(CHUNK);
    assign a_sl   = CHUNK'(a_q >> shamt);
    assign b_sl   = CHUNK'(b_q >> shamt);

    logic_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a   (a_sl),
        .b   (b_sl),
        .op  (op_q),
        .res (chunk_res),
        .pop (chunk_pop)
    );

    // accumulator starts cleared, so OR-ing each chunk into place is enough
    assign low_next = acc_low | (WIDTH'(chunk_res) << shamt);
    assign cnt_next = acc_cnt + CNT_W'(chunk_pop);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx      <= '0;
            acc_low  <= '0;
            acc_cnt  <= '0;
            res_low  <= '0;
            res_high <= '0;
        end else if (launch) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            idx     <= '0;
            acc_low <= '0;
            acc_cnt <= '0;
        end else if (state == RUN) begin
            acc_low <= low_next;
            acc_cnt <= cnt_next;
            idx     <= idx + IDX_W'(1);
            if (last) begin
                res_low  <= low_next;
                res_high <= WIDTH'(cnt_next);
            end
        end
    end

endmodule

// File: tb/tb_seq_logic_unit.sv
// tb/tb_seq_logic_unit.sv - directed self-checking bench for seq_logic_unit
module tb_seq_logic_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] a, b, a2, b2;
    logic [2:0]  op, op2;
    logic        start, start2;
    logic        busy, done, busy2, done2;
    logic [31:0] res_low, res_high, res_low2, res_high2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    seq_logic_unit dut (
        .clock(clock), .reset(reset), .a(a), .b(b), .op(op), .start(start),
        .busy(busy), .done(done), .res_low(res_low), .res_high(res_high)
    );

    seq_logic_unit #(.WIDTH(32), .CHUNK(16)) dut16 (
        .clock(clock), .reset(reset), .a(a2), .b(b2), .op(op2), .start(start2),
        .busy(busy2), .done(done2), .res_low(res_low2), .res_high(res_high2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch in the current cycle (cycle 0); done expected in cycle 5 only.
    // glitch > 0 pulses start with other operands in that RUN cycle.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] top,
                         input logic [31:0] el, input logic [31:0] eh, input int glitch,
                         input string tag);
        logic [31:0] held_low, held_high;
        held_low  = res_low;
        held_high = res_high;
        a = ta; b = tb_v; op = top; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_run_done"}, {31'd0, done}, 32'd0);
            check({tag, "_run_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_run_hold_low"}, res_low, held_low);
            check({tag, "_run_hold_high"}, res_high, held_high);
            if (k == glitch) begin
                a = 32'h0; b = 32'h0; op = 3'b011; start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        check({tag, "_res_low"}, res_low, el);
        check({tag, "_res_high"}, res_high, eh);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; op = '0; a2 = '0; b2 = '0; op2 = '0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_low", res_low, 32'd0);
        check("rst_high", res_high, 32'd0);
        reset = 1'b0;
        step();

        do_op(32'hFFFF0000, 32'h0F0F0F0F, 3'b010, 32'hF0F00F0F, 32'd16, 0, "xor");
        step();
        check("idle_after_done", {31'd0, done}, 32'd0);

        do_op(32'h00000000, 32'h00000000, 3'b011, 32'hFFFFFFFF, 32'd32, 0, "nor");
        do_op(32'hFFFFFFFF, 32'h00000000, 3'b000, 32'h00000000, 32'd0, 0, "and_b2b");
        step();

        do_op(32'hFFFF0000, 32'hFF00FF00, 3'b100, 32'hFF0000FF, 32'd16, 0, "xnor");
        step();

        do_op(32'h12345678, 32'hFF00FF00, 3'b000, 32'h12005600, 32'd6, 2, "ignore_start");
        step();

        // reset asserted in cycle 3 of a RUN
        a = 32'hA5A5A5A5; b = 32'h0; op = 3'b010; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_low", res_low, 32'd0);
        check("abort_high", res_high, 32'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (done) seen++;
                step();
            end
            check("abort_no_done", 32'(seen), 32'd0);
        end

        do_op(32'h000000FF, 32'h0F000000, 3'b001, 32'h0F0000FF, 32'd12, 0, "or");
        step();
        do_op(32'hFFFFFFFF, 32'h12345678, 3'b111, 32'h00000000, 32'd0, 0, "illegal");
        step();

        // CHUNK=16 instance: done in cycle 3
        a2 = 32'h12345678; b2 = 32'h0000FFFF; op2 = 3'b101; start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            check("c16_run_done", {31'd0, done2}, 32'd0);
            check("c16_run_busy", {31'd0, busy2}, 32'd1);
            step();
        end
        check("c16_done", {31'd0, done2}, 32'd1);
        check("c16_low", res_low2, 32'h12340000);
        check("c16_high", res_high2, 32'd5);
        step();
        check("c16_done_cleared", {31'd0, done2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_logic_unit.md
SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width.
REQ-002 The block SHALL have parameter CHUNK, default 8, the bits processed per cycle; WIDTH % CHUNK == 0 is required, with NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port op, input, 3 bits: operation select.
REQ-009 The block SHALL have port start, input, 1 bit: request; sampled only when idle or done.
REQ-010 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port res_low, output, WIDTH bits: logic result.
REQ-013 The block SHALL have port res_high, output, WIDTH bits: population count of res_low, zero-extended.

Function
REQ-014 op encoding SHALL be 000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 ANDN (a & ~b); codes 110 and 111 are illegal.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE with start=1, the block SHALL latch a, b and op, clear the internal result and count accumulators and chunk index, and go to RUN.
REQ-017 In RUN, each cycle SHALL process chunk index i (bits i*CHUNK+CHUNK-1 : i*CHUNK), lowest chunk first, writing the chunk result and adding its popcount to the accumulator.
REQ-018 After chunk NCHUNK-1, the FSM SHALL go to DONE; res_low and res_high SHALL load from the accumulators on that same edge.
REQ-019 Latency: with start high in cycle 0, done SHALL be 1 exactly in cycle NCHUNK+1 (cycle 5 for the defaults).
REQ-020 DONE SHALL last one cycle, then return to IDLE unless start=1, which begins a new operation back-to-back.
REQ-021 busy SHALL be 1 only in RUN; start SHALL be ignored while busy, and operands and op SHALL not be resampled then.
REQ-022 res_low and res_high SHALL hold their last value from DONE entry until the next DONE entry; they SHALL not change during RUN.
REQ-023 An illegal op SHALL run the full NCHUNK cycles, give res_low=0 and res_high=0, and pulse done normally.
REQ-024 Popcount SHALL range 0..WIDTH, and the accumulator SHALL be at least clog2(WIDTH+1) bits with no overflow.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL enter IDLE and set busy=0, done=0, res_low=0, res_high=0, and clear the index, accumulators and latched operands.
REQ-026 Reset SHALL take priority over start and over any in-progress RUN; the aborted operation SHALL produce no done pulse.

Structure
REQ-027 A shared package SHALL hold the op encoding constants and the state enum typedef (IDLE, RUN, DONE).
REQ-028 One combinational sub-module, logic_chunk, parametrised by CHUNK, SHALL take chunk slices of a and b plus op and return the chunk result and its popcount; the top-level SHALL instantiate it once.

Verification
REQ-029 Bench SHALL check: XOR, a=0xFFFF0000, b=0x0F0F0F0F, start in cycle 0 -> done in cycle 5 only, res_low=0xF0F00F0F, res_high=16.
REQ-030 Bench SHALL check: NOR, a=0, b=0 -> res_low=0xFFFFFFFF, res_high=32; then AND, a=0xFFFFFFFF, b=0, started in the DONE cycle -> next done 5 cycles later, res_low=0, res_high=0.
REQ-031 Bench SHALL check: start pulsed in cycle 2 of a RUN with different operands -> ignored, and the result matches the original operands.
REQ-032 Bench SHALL check: reset asserted in cycle 3 of a RUN -> next cycle busy=0, res_low=0, res_high=0, and no done pulse.
REQ-033 Bench SHALL check: op=111, any operands -> done in cycle 5, res_low=0, res_high=0.
REQ-034 Bench SHALL check: WIDTH=32, CHUNK=16, ANDN, a=0x12345678, b=0x0000FFFF -> done in cycle 3, res_low=0x12340000, res_high=5.
